obs_mult82_sequencer: RTL and testbench
=======================================

# obs_mult82_sequencer

Sequencer for the 82-bit level of the OBS binary-field multiplier. It accepts two 82-bit operands and splits each into even- and odd-indexed 41-bit halves. It time-shares one external 41x41 sub-multiplier over four issue slots and captures the four 81-bit partial products. It then presents the 163-bit product through `overlap_module_82bit`, with ready/valid handshakes on both sides.

## Interface
Parameters:
- `N`, 82: operand width.
- `MUL_LAT`, 1: fixed latency of the sub-multiplier in cycles (0..4). 0 means `mul_res` is valid in the issue cycle.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: block can accept operands.
- `a_in`, in, 82: operand A. Bit i is the coefficient of x^i.
- `b_in`, in, 82: operand B.
- `mul_valid`, out, 1: issue strobe to the sub-multiplier.
- `mul_a`, out, 41: sub-multiplier operand.
- `mul_b`, out, 41: sub-multiplier operand.
- `mul_res`, in, 81: sub-multiplier result, valid `MUL_LAT` cycles after the matching `mul_valid`.
- `out_valid`, out, 1: product valid.
- `out_ready`, in, 1: consumer accepts the product.
- `res`, out, 163: GF(2)[x] product A·B, unreduced.

## Operation
- Operand split: `ae[i]=a[2i]`, `ao[i]=a[2i+1]` for i=0..40; B is split the same way.
- States and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, register both operands and go to ISSUE.
  - ISSUE: 4 cycles, slot counter k=0..3, `mul_valid`=1. Go to DRAIN after k=3, or straight to DONE when `MUL_LAT`=0.
  - DRAIN: wait `MUL_LAT` cycles for the last result. The state is skipped when `MUL_LAT`=0.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Slot assignment:
  - k=0: `ae*be`, stored to P1.
  - k=1: `ae*bo`, stored to P2.
  - k=2: `ao*be`, stored to P3.
  - k=3: `ao*bo`, stored to P4.
- Result capture: a `MUL_LAT`-deep shift register carries {valid, 2-bit slot tag}. `mul_res` is written to P[tag] on the cycle the tag emerges. No other write path to P1..P4 exists.
- Recombination: `res` = overlap of (P1, P2, P3, P4).
  - Even bit 2i = P1[i] ^ P4[i-1].
  - Odd bit 2i+1 = P2[i] ^ P3[i].
  - Bit 0 = P1[0].
  - Bit 162 = P4[80].
- When `mul_valid`=0, `mul_a` and `mul_b` are 0.
- `in_ready` is 1 only in IDLE and never in the cycle the output handshake completes. Accept and output never overlap.
- `in_valid` in any non-IDLE state is ignored. Operands are not sampled.
- Reset values: state IDLE, `out_valid`=0, `mul_valid`=0, `mul_a`=0, `mul_b`=0, P1..P4=0, so `res`=0. The tag pipe is cleared. `in_ready` is forced 0 while `rst_n`=0.
- Reset mid-operation (any state): all in-flight tags are discarded and the block returns to IDLE on the next edge. A stale `mul_res` arriving afterwards is not captured.

## Timing
- Accept at edge E0. ISSUE occupies cycles 1..4 after E0.
- `out_valid` rises in cycle 5+`MUL_LAT` after E0.
- Initiation interval is 6+`MUL_LAT` cycles with `out_ready` held high.
- `res` and `out_valid` are held stable while `out_ready`=0, for unbounded backpressure.
- `in_ready` returns to 1 in the cycle after the output handshake.
- `res` is combinational from registers P1..P4 only. There is no path from `mul_res` to `res` in the same cycle.

## Structure
- Shared package `obs_pkg` holds:
  - constants `OBS_N82=82`, `OBS_H41=41`, `OBS_P81=81`;
  - the state enum `obs_seq_state_t` {IDLE, ISSUE, DRAIN, DONE};
  - the slot tag type `obs_slot_t` (2 bits).
- Sub-module: instantiate the existing `overlap_module_82bit` for recombination. Do not re-implement it inline.

## Test plan
- a=1, b=1, `MUL_LAT`=1 -> `out_valid` in cycle 6 after accept, `res`=1. Exactly 4 `mul_valid` pulses, with (`mul_a`,`mul_b`) = (1,1), (1,0), (0,1), (0,0).
- a=2, b=2 (x·x) -> `res`=4. a=2^81, b=2^81 -> `res`=2^162 (bit 162 only).
- a=2^82-1, b=1 -> `res`=2^82-1. a=b=2^82-1 -> `res` has bits at even positions 0..162 only. Run with `MUL_LAT`=0, 1 and 4; results are identical and latency is 5, 6 and 9.
- Hold `out_ready`=0 for 10 cycles in DONE -> `res` stable, `in_ready`=0, extra `in_valid` ignored. Releasing `out_ready` -> handshake completes, `in_ready`=1 in the next cycle.
- Assert `rst_n`=0 during ISSUE slot 2 -> next cycle: `mul_valid`=0, `out_valid`=0, `res`=0. A fresh operation afterwards yields the correct product with no stale P contamination.
- 1000 back-to-back random operand pairs checked against a bit-serial carry-less reference model, with random `out_ready` stalls -> all products match, in order.

Source files
------------

// File: rtl/obs_pkg.sv
// Shared types and constants for the OBS binary-field multiplier, 82-bit level.
package obs_pkg;

  localparam int OBS_N82  = 82;
  localparam int OBS_H41  = 41;
  localparam int OBS_P81  = 81;
  localparam int OBS_R163 = 163;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } obs_seq_state_t;

  typedef logic [1:0] obs_slot_t;

  // One stage of the result-capture pipe: which partial product is in flight.
  typedef struct packed {
    logic      valid;
    obs_slot_t slot;
  } obs_tag_t;

  // Gather the even-indexed (odd_sel=0) or odd-indexed (odd_sel=1) coefficients.
  function automatic logic [OBS_H41-1:0] obs_half(input logic [OBS_N82-1:0] x,
                                                  input logic odd_sel);
    logic [OBS_H41-1:0] h;
    h = {OBS_H41{1'b0}};
    for (int i = 0; i < OBS_H41; i++) begin
      h[i] = odd_sel ? x[2*i+1] : x[2*i];
    end
    return h;
  endfunction

endpackage

// File: rtl/overlap_module_82bit.sv
// Recombines the four 81-bit half products into the 163-bit 82x82 product.
// A = ae(x^2) + x*ao(x^2), so even bits come from ae*be and x^2*ao*bo,
// odd bits from the two cross terms.
module overlap_module_82bit
  import obs_pkg::*;
(
  input  logic [OBS_P81-1:0]  p1,
  input  logic [OBS_P81-1:0]  p2,
  input  logic [OBS_P81-1:0]  p3,
  input  logic [OBS_P81-1:0]  p4,
  output logic [OBS_R163-1:0] res
);

  logic [OBS_R163-1:0] res_s;

  // Interleave the partial products; P4 is shifted up by one even position.
  always_comb begin
    res_s = {OBS_R163{1'b0}};
    res_s[0] = p1[0];
    for (int i = 1; i < OBS_P81; i++) begin
      res_s[2*i] = p1[i] ^ p4[i-1];
    end
    res_s[OBS_R163-1] = p4[OBS_P81-1];
    for (int i = 0; i < OBS_P81; i++) begin
      res_s[2*i+1] = p2[i] ^ p3[i];
    end
  end

  assign res = res_s;

endmodule

// File: rtl/obs_mult82_sequencer.sv
// Time-shares one external 41x41 carry-less multiplier over four slots to
// build an 82x82 GF(2)[x] product; ready/valid on operand and result sides.
module obs_mult82_sequencer
  import obs_pkg::*;
#(
  parameter int N       = 82,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             mul_valid,
  output logic [N/2-1:0]   mul_a,
  output logic [N/2-1:0]   mul_b,
  input  logic [N-2:0]     mul_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   res
);

  // Last drain-counter value before the final result lands.
  localparam logic [2:0] LAT_LAST = (MUL_LAT == 0) ? 3'd0 : 3'(MUL_LAT - 1);

  obs_seq_state_t     state_r, state_nx_s;
  obs_slot_t          slot_r, slot_nx_s, slot_inc_s;
  logic [2:0]         lat_cnt_r, lat_cnt_nx_s;
  logic [OBS_N82-1:0] a_r, b_r, a_nx_s, b_nx_s;
  logic               mul_valid_r, mul_valid_nx_s;
  logic [OBS_H41-1:0] mul_a_r, mul_b_r, mul_a_nx_s, mul_b_nx_s;
  obs_slot_t          mul_tag_r, mul_tag_nx_s;
  logic               out_valid_r, out_valid_nx_s;
  logic               in_ready_r, in_ready_nx_s;
  logic [OBS_P81-1:0] p1_r, p2_r, p3_r, p4_r;
  logic               cap_valid_s;
  obs_slot_t          cap_slot_s;

  assign slot_inc_s = slot_r + 2'd1;

  // Next-state and next-output decode; issue operands are prepared one cycle ahead.
  always_comb begin
    state_nx_s     = state_r;
    slot_nx_s      = slot_r;
    lat_cnt_nx_s   = lat_cnt_r;
    a_nx_s         = a_r;
    b_nx_s         = b_r;
    mul_valid_nx_s = 1'b0;
    mul_a_nx_s     = {OBS_H41{1'b0}};
    mul_b_nx_s     = {OBS_H41{1'b0}};
    mul_tag_nx_s   = 2'd0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s     = ISSUE;
          slot_nx_s      = 2'd0;
          a_nx_s         = a_in;
          b_nx_s         = b_in;
          mul_valid_nx_s = 1'b1;
          mul_a_nx_s     = obs_half(a_in, 1'b0);
          mul_b_nx_s     = obs_half(b_in, 1'b0);
          mul_tag_nx_s   = 2'd0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (slot_r == 2'd3) begin
          lat_cnt_nx_s = 3'd0;
          if (MUL_LAT == 0) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = DRAIN;
          end
        end else begin
          // Slot k: A half = k[1] (even/odd), B half = k[0].
          slot_nx_s      = slot_inc_s;
          mul_valid_nx_s = 1'b1;
          mul_a_nx_s     = obs_half(a_r, slot_inc_s[1]);
          mul_b_nx_s     = obs_half(b_r, slot_inc_s[0]);
          mul_tag_nx_s   = slot_inc_s;
        end
      end
      DRAIN: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_nx_s = DONE;
        end else begin
          lat_cnt_nx_s = lat_cnt_r + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    out_valid_nx_s = (state_nx_s == DONE);
    in_ready_nx_s  = (state_nx_s == IDLE);
  end

  // Control, operand and issue-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      slot_r      <= 2'd0;
      lat_cnt_r   <= 3'd0;
      a_r         <= {OBS_N82{1'b0}};
      b_r         <= {OBS_N82{1'b0}};
      mul_valid_r <= 1'b0;
      mul_a_r     <= {OBS_H41{1'b0}};
      mul_b_r     <= {OBS_H41{1'b0}};
      mul_tag_r   <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      slot_r      <= slot_nx_s;
      lat_cnt_r   <= lat_cnt_nx_s;
      a_r         <= a_nx_s;
      b_r         <= b_nx_s;
      mul_valid_r <= mul_valid_nx_s;
      mul_a_r     <= mul_a_nx_s;
      mul_b_r     <= mul_b_nx_s;
      mul_tag_r   <= mul_tag_nx_s;
      out_valid_r <= out_valid_nx_s;
      in_ready_r  <= in_ready_nx_s;
    end
  end

  // The tag follows the sub-multiplier latency so each result lands in its own P register.
  if (MUL_LAT == 0) begin : g_lat0
    assign cap_valid_s = mul_valid_r;
    assign cap_slot_s  = mul_tag_r;
  end else begin : g_latn
    obs_tag_t tag_pipe_r [MUL_LAT];

    // Tag shift register; cleared on reset so stale results are never captured.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < MUL_LAT; i++) begin
          tag_pipe_r[i] <= '{valid: 1'b0, slot: 2'd0};
        end
      end else begin
        tag_pipe_r[0] <= '{valid: mul_valid_r, slot: mul_tag_r};
        for (int i = 1; i < MUL_LAT; i++) begin
          tag_pipe_r[i] <= tag_pipe_r[i-1];
        end
      end
    end

    assign cap_valid_s = tag_pipe_r[MUL_LAT-1].valid;
    assign cap_slot_s  = tag_pipe_r[MUL_LAT-1].slot;
  end

  // Partial-product capture: the only write path into P1..P4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_r <= {OBS_P81{1'b0}};
      p2_r <= {OBS_P81{1'b0}};
      p3_r <= {OBS_P81{1'b0}};
      p4_r <= {OBS_P81{1'b0}};
    end else if (cap_valid_s) begin
      case (cap_slot_s)
        2'd0:    p1_r <= mul_res;
        2'd1:    p2_r <= mul_res;
        2'd2:    p3_r <= mul_res;
        2'd3:    p4_r <= mul_res;
        default: p1_r <= p1_r;
      endcase
    end
  end

  overlap_module_82bit u_overlap (
    .p1  (p1_r),
    .p2  (p2_r),
    .p3  (p3_r),
    .p4  (p4_r),
    .res (res)
  );

  assign in_ready  = in_ready_r & rst_n;
  assign mul_valid = mul_valid_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_obs_mult82_sequencer.sv
// Directed and random checks of obs_mult82_sequencer at MUL_LAT = 0, 1 and 4,
// all three instances driven by the same operand/handshake stimulus.
module tb_obs_mult82_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [81:0]  a_in, b_in;
  logic [2:0]   in_ready_w, mul_valid_w, out_valid_w;
  logic [40:0]  mul_a_w [3];
  logic [40:0]  mul_b_w [3];
  logic [80:0]  mul_res_w [3];
  logic [162:0] res_w [3];

  int n_vec = 0;
  int n_err = 0;

  // Instance-1 issue trace collected by do_op.
  logic [40:0] pa [4];
  logic [40:0] pb [4];
  int          pulse_cnt;
  logic        idle_zero_ok;

  localparam logic [80:0] JUNK = {81{1'b1}};

  function automatic logic [80:0] clmul41(input logic [40:0] x, input logic [40:0] y);
    logic [80:0] r;
    r = 81'd0;
    for (int i = 0; i < 41; i++) begin
      if (x[i]) r = r ^ ({40'd0, y} << i);
    end
    return r;
  endfunction

  function automatic logic [162:0] clmul82(input logic [81:0] x, input logic [81:0] y);
    logic [162:0] r;
    r = 163'd0;
    for (int i = 0; i < 82; i++) begin
      if (x[i]) r = r ^ ({81'd0, y} << i);
    end
    return r;
  endfunction

  function automatic int lat_of(input int g);
    case (g)
      0:       return 0;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 0 : ((g == 1) ? 1 : 4);

    obs_mult82_sequencer #(.N(82), .MUL_LAT(LAT_G)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a_in      (a_in),
      .b_in      (b_in),
      .mul_valid (mul_valid_w[g]),
      .mul_a     (mul_a_w[g]),
      .mul_b     (mul_b_w[g]),
      .mul_res   (mul_res_w[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .res       (res_w[g])
    );

    // Sub-multiplier model; drives junk whenever no result is due.
    if (LAT_G == 0) begin : g_comb
      assign mul_res_w[g] = mul_valid_w[g] ? clmul41(mul_a_w[g], mul_b_w[g]) : JUNK;
    end else begin : g_pipe
      logic [80:0] pd [LAT_G];
      logic        pv [LAT_G];
      always @(posedge clk) begin
        pd[0] <= clmul41(mul_a_w[g], mul_b_w[g]);
        pv[0] <= mul_valid_w[g];
        for (int i = 1; i < LAT_G; i++) begin
          pd[i] <= pd[i-1];
          pv[i] <= pv[i-1];
        end
      end
      assign mul_res_w[g] = pv[LAT_G-1] ? pd[LAT_G-1] : JUNK;
    end
  end

  // One operation with out_ready high: checks latency, product and in_ready return.
  task automatic do_op(input logic [81:0] a, input logic [81:0] b,
                       input logic [162:0] exp_res, input string name);
    int         cyc;
    logic [2:0] seen;
    logic [2:0] rdy_chk;
    pulse_cnt    = 0;
    idle_zero_ok = 1'b1;
    out_ready    = 1'b1;
    a_in         = a;
    b_in         = b;
    in_valid     = 1'b1;
    n_vec++;
    if (in_ready_w !== 3'b111) begin
      n_err++;
      $display("FAIL %s accept_ready: got %b want 111", name, in_ready_w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen     = 3'b000;
    rdy_chk  = 3'b000;
    cyc      = 1;
    while ((rdy_chk != 3'b111) && (cyc < 30)) begin
      if (mul_valid_w[1]) begin
        if (pulse_cnt < 4) begin
          pa[pulse_cnt] = mul_a_w[1];
          pb[pulse_cnt] = mul_b_w[1];
        end
        pulse_cnt++;
      end else if ((mul_a_w[1] !== 41'd0) || (mul_b_w[1] !== 41'd0)) begin
        idle_zero_ok = 1'b0;
      end
      for (int g = 0; g < 3; g++) begin
        if (seen[g] && !rdy_chk[g]) begin
          rdy_chk[g] = 1'b1;
          n_vec++;
          if (in_ready_w[g] !== 1'b1 || out_valid_w[g] !== 1'b0) begin
            n_err++;
            $display("FAIL %s ready_after_hs lat%0d: got rdy=%b ov=%b want rdy=1 ov=0",
                     name, lat_of(g), in_ready_w[g], out_valid_w[g]);
          end
        end else if (!seen[g] && out_valid_w[g]) begin
          seen[g] = 1'b1;
          n_vec++;
          if (cyc != 5 + lat_of(g)) begin
            n_err++;
            $display("FAIL %s latency lat%0d: got %0d want %0d", name, lat_of(g), cyc, 5 + lat_of(g));
          end
          n_vec++;
          if (res_w[g] !== exp_res) begin
            n_err++;
            $display("FAIL %s res lat%0d: got %h want %h", name, lat_of(g), res_w[g], exp_res);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (rdy_chk !== 3'b111) begin
      n_err++;
      $display("FAIL %s timeout: got done=%b want 111", name, rdy_chk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = 82'd0;
    b_in      = 82'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (in_ready_w[g] !== 1'b0 || mul_valid_w[g] !== 1'b0 || out_valid_w[g] !== 1'b0 ||
          res_w[g] !== 163'd0 || mul_a_w[g] !== 41'd0 || mul_b_w[g] !== 41'd0) begin
        n_err++;
        $display("FAIL reset_state lat%0d: got rdy=%b mv=%b ov=%b res=%h want 0", lat_of(g),
                 in_ready_w[g], mul_valid_w[g], out_valid_w[g], res_w[g]);
      end
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready_w !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 111", in_ready_w);
    end
  endtask

  task automatic test_basic();
    logic [40:0] ea, eb;
    do_op(82'd1, 82'd1, 163'd1, "one_x_one");
    n_vec++;
    if (pulse_cnt != 4) begin
      n_err++;
      $display("FAIL mul_pulses: got %0d want 4", pulse_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      ea = (k < 2) ? 41'd1 : 41'd0;
      eb = ((k % 2) == 0) ? 41'd1 : 41'd0;
      n_vec++;
      if (pa[k] !== ea || pb[k] !== eb) begin
        n_err++;
        $display("FAIL slot%0d_operands: got (%0d,%0d) want (%0d,%0d)", k, pa[k], pb[k], ea, eb);
      end
    end
    n_vec++;
    if (idle_zero_ok !== 1'b1) begin
      n_err++;
      $display("FAIL mul_idle_zero: got %b want 1", idle_zero_ok);
    end
  endtask

  task automatic test_vectors();
    logic [81:0]  one_hi, ones;
    logic [162:0] top_bit, evens;
    one_hi  = 82'd1 << 81;
    ones    = {82{1'b1}};
    top_bit = 163'd1 << 162;
    evens   = {1'b1, {81{2'b01}}};
    do_op(82'd2, 82'd2, 163'd4, "x_sq");
    do_op(one_hi, one_hi, top_bit, "top_sq");
    do_op(ones, 82'd1, {81'd0, ones}, "ones_x_one");
    do_op(ones, ones, evens, "ones_sq");
    do_op(82'd5, 82'd3, 163'd15, "small");
  endtask

  task automatic test_backpressure();
    logic [162:0] exp_res;
    int           cyc;
    exp_res   = (163'd1 << 82) | 163'd1;
    out_ready = 1'b0;
    a_in      = {82{1'b1}};
    b_in      = 82'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    // Operands offered outside IDLE must be ignored.
    a_in = 82'h2_DEAD_BEEF_0123_4567_89AB;
    b_in = 82'h1_F0F0_F0F0_0F0F_0F0F_AAAA;
    cyc  = 0;
    while ((out_valid_w !== 3'b111) && (cyc < 20)) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (out_valid_w !== 3'b111) begin
      n_err++;
      $display("FAIL bp_reach_done: got %b want 111", out_valid_w);
    end
    for (int c = 0; c < 10; c++) begin
      for (int g = 0; g < 3; g++) begin
        n_vec++;
        if (res_w[g] !== exp_res || in_ready_w[g] !== 1'b0 || out_valid_w[g] !== 1'b1 ||
            mul_valid_w[g] !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold lat%0d: got res=%h rdy=%b ov=%b mv=%b want res=%h rdy=0 ov=1 mv=0",
                   lat_of(g), res_w[g], in_ready_w[g], out_valid_w[g], mul_valid_w[g], exp_res);
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready_w !== 3'b111 || out_valid_w !== 3'b000) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b ov=%b want rdy=111 ov=000", in_ready_w, out_valid_w);
    end
    do_op(82'd6, 82'd3, 163'd10, "after_bp");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    a_in      = {82{1'b1}};
    b_in      = {82{1'b1}};
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (mul_valid_w !== 3'b111) begin
      n_err++;
      $display("FAIL rm_in_issue: got %b want 111", mul_valid_w);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (mul_valid_w[g] !== 1'b0 || out_valid_w[g] !== 1'b0 || res_w[g] !== 163'd0 ||
          in_ready_w[g] !== 1'b0) begin
        n_err++;
        $display("FAIL rm_cleared lat%0d: got mv=%b ov=%b rdy=%b res=%h want 0", lat_of(g),
                 mul_valid_w[g], out_valid_w[g], in_ready_w[g], res_w[g]);
      end
    end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (res_w[g] !== 163'd0 || in_ready_w[g] !== 1'b1) begin
        n_err++;
        $display("FAIL rm_no_stale lat%0d: got res=%h rdy=%b want res=0 rdy=1", lat_of(g),
                 res_w[g], in_ready_w[g]);
      end
    end
    do_op(82'd5, 82'd3, 163'd15, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [95:0]  ra, rb;
    logic [81:0]  a, b;
    logic [162:0] exp_res;
    logic [2:0]   done;
    int           cyc;
    for (int n = 0; n < 1000; n++) begin
      ra      = {$urandom, $urandom, $urandom};
      rb      = {$urandom, $urandom, $urandom};
      a       = ra[81:0];
      b       = rb[81:0];
      exp_res = clmul82(a, b);
      cyc     = 0;
      while ((in_ready_w !== 3'b111) && (cyc < 20)) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_vec++;
      if (in_ready_w !== 3'b111) begin
        n_err++;
        $display("FAIL rnd%0d ready: got %b want 111", n, in_ready_w);
      end
      a_in     = a;
      b_in     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      done     = 3'b000;
      cyc      = 0;
      while ((done !== 3'b111) && (cyc < 80)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        for (int g = 0; g < 3; g++) begin
          if (!done[g] && out_valid_w[g] && out_ready) begin
            done[g] = 1'b1;
            n_vec++;
            if (res_w[g] !== exp_res) begin
              n_err++;
              $display("FAIL rnd%0d res lat%0d: got %h want %h", n, lat_of(g), res_w[g], exp_res);
            end
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      n_vec++;
      if (done !== 3'b111) begin
        n_err++;
        $display("FAIL rnd%0d timeout: got done=%b want 111", n, done);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
